// File: rtl/sumator_scazator_serial.sv
// Serial add/sub unit: processes CHUNK bits per cycle, LSB first, through a registered carry.
// Latency: WIDTH/CHUNK cycles from start capture to done. Back-to-back throughput is one op per N+1 cycles.
// No backpressure: start is only accepted in IDLE/DONE and is ignored while busy. Optional ovf via SUMATOR_SERIAL_OVF_EN.
module sumator_scazator_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s_mod,
    output logic             Cout,
    output logic             zero,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operand shift registers, carry and chunk counter
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_part;

    // Held result registers
    logic [WIDTH-1:0] r_s_mod;
    logic             r_cout;
    logic             r_zero;

    // Control strobes from the FSM
    logic w_load;
    logic w_step;
    logic w_last;

    // Per-chunk adder
    logic [CHUNK:0]   w_chunk_sum;
    logic [CHUNK-1:0] w_csum;
    logic             w_cout_chunk;
    logic [WIDTH-1:0] w_csum_ext;
    logic [WIDTH-1:0] w_part_nxt;

    assign w_chunk_sum  = {1'b0, r_a[CHUNK-1:0]}
                        + {1'b0, r_b[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, r_carry};
    assign w_csum       = w_chunk_sum[CHUNK-1:0];
    assign w_cout_chunk = w_chunk_sum[CHUNK];

    // New chunk enters at the top; after N steps the partial register holds the full sum LSB-aligned.
    assign w_csum_ext   = WIDTH'(w_csum);
    assign w_part_nxt   = (r_part >> CHUNK) | (w_csum_ext << (WIDTH - CHUNK));

    assign w_last       = (r_cnt == CNT_W'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture and per-chunk shifting; subtract is A + ~B + 1 with the +1 as initial carry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_part  <= '0;
        end else if (w_load) begin
            r_a     <= in_1;
            r_b     <= sub ? ~in_2 : in_2;
            r_carry <= sub;
            r_cnt   <= '0;
            r_part  <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_cout_chunk;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_part  <= w_part_nxt;
        end
    end

    // Result registers only move on the completion edge of the final chunk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_mod <= '0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_step && w_last) begin
            r_s_mod <= w_part_nxt;
            r_cout  <= w_cout_chunk;
            r_zero  <= (w_part_nxt == '0);
        end
    end

    assign s_mod = r_s_mod;
    assign Cout  = r_cout;
    assign zero  = r_zero;

`ifdef SUMATOR_SERIAL_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: cin = a ^ b ^ s
    logic w_msb_cin;
    logic r_ovf;

    assign w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_csum[CHUNK-1];

    // Two's-complement overflow captured alongside the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_step && w_last) begin
            r_ovf <= w_msb_cin ^ w_cout_chunk;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sumator_scazator_serial.sv
// Bench for sumator_scazator_serial with WIDTH=8, CHUNK=2 (four chunks per op).
// Expected results are queued when an op is issued and popped when done is seen.
// All stimulus is driven and all outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_sumator_scazator_serial;

`ifdef SUMATOR_SERIAL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] in_1;
    logic [7:0] in_2;
    logic       busy;
    logic       done;
    logic [7:0] s_mod;
    logic       Cout;
    logic       zero;
    logic       ovf;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {s_mod, Cout, zero, ovf}
    logic [10:0] exp_q[$];

    // Directed operations: a, b, sub, expected {s_mod, Cout, zero, ovf}
    localparam logic [7:0]  TA [7] = '{8'h07, 8'hC8, 8'h38, 8'h02, 8'h0C, 8'hAA, 8'h7F};
    localparam logic [7:0]  TB [7] = '{8'h38, 8'h64, 8'h07, 8'h03, 8'h0C, 8'h55, 8'h01};
    localparam logic        TS [7] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
    localparam logic [10:0] TE [7] = '{
        {8'h3F, 1'b0, 1'b0, 1'b0},
        {8'h2C, 1'b1, 1'b0, 1'b0},
        {8'h31, 1'b1, 1'b0, 1'b0},
        {8'hFF, 1'b0, 1'b0, 1'b0},
        {8'h00, 1'b1, 1'b1, 1'b0},
        {8'h55, 1'b1, 1'b0, OVF_EN},
        {8'h80, 1'b0, 1'b0, OVF_EN}
    };

    sumator_scazator_serial #(
        .WIDTH(8),
        .CHUNK(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .in_1  (in_1),
        .in_2  (in_2),
        .busy  (busy),
        .done  (done),
        .s_mod (s_mod),
        .Cout  (Cout),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference model of the full-width operation
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] bb;
        logic [8:0] r;
        logic       o;
        bb = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {8'd0, s};
        o  = (a[7] == bb[7]) && (r[7] != a[7]);
        return {r[7:0], r[8], (r[7:0] == 8'd0), o & OVF_EN};
    endfunction

    // Drive one start cycle from a falling edge; returns on the falling edge after capture
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [10:0] e, input bit push);
        in_1  = a;
        in_2  = b;
        sub   = s;
        start = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges until done (bounded) and busy samples seen on the way
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_exp(output logic [10:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 'x;
    endtask

    task automatic test_reset();
        int dcnt;
        int bcnt;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        in_1  = 8'h00;
        in_2  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, s_mod, Cout, zero, ovf} !== 13'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b s=%h c=%b z=%b o=%b, want all 0",
                     busy, done, s_mod, Cout, zero, ovf);
        else n_pass++;
        dcnt = 0;
        bcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
            if (busy !== 1'b0) bcnt++;
        end
        n_checks++;
        if (dcnt !== 0 || bcnt !== 0)
            $display("FAIL reset_idle: got done_pulses=%0d busy_cycles=%0d, want 0/0", dcnt, bcnt);
        else n_pass++;
    endtask

    task automatic test_directed();
        int lat;
        int bcnt;
        logic [10:0] e;
        for (int i = 0; i < 7; i++) begin
            issue(TA[i], TB[i], TS[i], TE[i], 1'b1);
            wait_done(lat, bcnt);
            pop_exp(e);
            n_checks++;
            if (lat !== 4) $display("FAIL dir%0d_latency: got %0d want 4", i, lat);
            else n_pass++;
            n_checks++;
            if (bcnt !== 4) $display("FAIL dir%0d_busy: got %0d cycles want 4", i, bcnt);
            else n_pass++;
            n_checks++;
            if ({s_mod, Cout, zero, ovf} !== e)
                $display("FAIL dir%0d_result: got s=%h c=%b z=%b o=%b want s=%h c=%b z=%b o=%b",
                         i, s_mod, Cout, zero, ovf, e[10:3], e[2], e[1], e[0]);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || {s_mod, Cout, zero, ovf} !== e)
                $display("FAIL dir%0d_pulse: got done=%b s=%h want done=0 s=%h", i, done, s_mod, e[10:3]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [10:0] held;
        int bad;
        held = {s_mod, Cout, zero, ovf};
        bad  = 0;
        for (int i = 0; i < 6; i++) begin
            in_1 = 8'($urandom);
            in_2 = 8'($urandom);
            sub  = 1'($urandom);
            @(negedge clk);
            if ({s_mod, Cout, zero, ovf} !== held || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0 || held !== TE[6])
            $display("FAIL hold: got %0d disturbed cycles, held=%h want 0 and %h", bad, held, TE[6]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int bcnt;
        logic [10:0] e;
        // start held high through RUN: operand changes mid-RUN must be ignored
        in_1  = 8'h10;
        in_2  = 8'h20;
        sub   = 1'b0;
        start = 1'b1;
        exp_q.push_back({8'h30, 3'b000});
        @(negedge clk);
        in_1 = 8'h01;
        in_2 = 8'h01;
        exp_q.push_back({8'h02, 3'b000});
        wait_done(lat, bcnt);
        pop_exp(e);
        n_checks++;
        if (lat !== 4 || {s_mod, Cout, zero, ovf} !== e)
            $display("FAIL held_start_first: got lat=%0d s=%h want lat=4 s=%h", lat, s_mod, e[10:3]);
        else n_pass++;
        // start still high in DONE: re-launch with the operands present now
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL done_to_run: got busy=%b done=%b want busy=1 done=0", busy, done);
        else n_pass++;
        wait_done(lat, bcnt);
        pop_exp(e);
        n_checks++;
        if (lat + 1 !== 5 || {s_mod, Cout, zero, ovf} !== e)
            $display("FAIL held_start_second: got gap=%0d s=%h want gap=5 s=%h", lat + 1, s_mod, e[10:3]);
        else n_pass++;
        // start issued in the DONE cycle
        issue(8'h3C, 8'h3F, 1'b1, {8'hFD, 3'b000}, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_busy: got busy=%b done=%b want busy=1 done=0", busy, done);
        else n_pass++;
        wait_done(lat, bcnt);
        pop_exp(e);
        n_checks++;
        if (lat + 1 !== 5 || {s_mod, Cout, zero, ovf} !== e)
            $display("FAIL b2b_result: got gap=%0d s=%h c=%b want gap=5 s=%h c=%b",
                     lat + 1, s_mod, Cout, e[10:3], e[2]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        int bcnt;
        int dcnt;
        logic [10:0] e;
        issue(8'hAA, 8'h55, 1'b0, 11'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, s_mod, Cout, zero, ovf} !== 13'd0)
            $display("FAIL reset_mid_outputs: got busy=%b done=%b s=%h c=%b z=%b o=%b want all 0",
                     busy, done, s_mod, Cout, zero, ovf);
        else n_pass++;
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        n_checks++;
        if (dcnt !== 0) $display("FAIL reset_mid_no_done: got %0d pulses want 0", dcnt);
        else n_pass++;
        issue(8'h33, 8'hC3, 1'b0, {8'hF6, 3'b000}, 1'b1);
        wait_done(lat, bcnt);
        pop_exp(e);
        n_checks++;
        if (lat !== 4 || {s_mod, Cout, zero, ovf} !== e)
            $display("FAIL reset_mid_next: got lat=%0d s=%h c=%b want lat=4 s=%h c=%b",
                     lat, s_mod, Cout, e[10:3], e[2]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat;
        int bcnt;
        logic [10:0] e;
        logic [7:0] a;
        logic [7:0] b;
        logic s;
        for (int i = 0; i < 16; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            issue(a, b, s, model(a, b, s), 1'b1);
            wait_done(lat, bcnt);
            pop_exp(e);
            n_checks++;
            if (lat !== 4 || {s_mod, Cout, zero, ovf} !== e)
                $display("FAIL rand%0d: %h %s %h got lat=%0d s=%h c=%b z=%b o=%b want lat=4 s=%h c=%b z=%b o=%b",
                         i, a, s ? "-" : "+", b, lat, s_mod, Cout, zero, ovf, e[10:3], e[2], e[1], e[0]);
            else n_pass++;
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL queue_drained: got %0d left want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        in_1  = 8'h00;
        in_2  = 8'h00;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
